seg_chaser: RTL and testbench



---
 rtl/seg_pkg.sv | 19 +
 rtl/tick_gen.sv | 35 +++
 rtl/seg_chaser.sv | 121 ++++++++++++
 tb/tb_seg_chaser.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared segment types and the position-to-segment mapping used by the
// chaser and any other single-digit display block.
package seg_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_ALL_OFF_CA = 7'b1111111;
  localparam seg_t SEG_ALL_OFF_CC = 7'b0000000;

  // Position 0 drives bit 6 (segment a); polarity flips for common-anode parts.
  function automatic seg_t onehot_seg(input logic [2:0] pos, input logic common_anode);
    seg_t w_on;
    w_on = seg_t'(7'b1000000 >> pos);
    return common_anode ? (SEG_ALL_OFF_CA ^ w_on) : (SEG_ALL_OFF_CC | w_on);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Programmable prescaler: one-cycle tick every div+1 enabled clocks.
// Freezes (no tick, count held) while en is low.
module tick_gen #(
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  generate
    if (DIV_W < 1) begin : g_bad_div_w
      $error("tick_gen: DIV_W must be at least 1");
    end
  endgenerate

  logic [DIV_W-1:0] r_cnt;
  logic             w_wrap;

  // >= rather than == so a period shortened below the running count
  // terminates on the next enabled cycle instead of rolling all the way round.
  assign w_wrap = (r_cnt >= div);
  assign tick   = en & w_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/seg_chaser.sv
// Single-digit segment chase: one lit segment walks a ring of N_SEG
// positions, wrapping or ping-ponging, at a rate set by the prescaler.
module seg_chaser
  import seg_pkg::*;
#(
  parameter int N_SEG        = 6,
  parameter bit COMMON_ANODE = 1'b1,
  parameter int DIV_W        = 26,
  localparam int PW          = $clog2(N_SEG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic [DIV_W-1:0] div,
  output logic [6:0]       seg,
  output logic [PW-1:0]    pos,
  output logic             lap
);

  generate
    if (N_SEG < 2 || N_SEG > 7) begin : g_bad_n_seg
      $error("seg_chaser: N_SEG must be in 2..7");
    end
  endgenerate

  localparam logic [PW-1:0] LAST   = PW'(N_SEG - 1);
  localparam logic [PW-1:0] PENULT = PW'(N_SEG - 2);
  localparam logic [PW-1:0] ONE    = PW'(1);

  logic          w_tick;
  logic          w_dir_eff;
  logic [PW-1:0] w_pos_next;
  logic          w_dir_next;
  logic          w_lap_next;

  logic [PW-1:0] r_pos;
  logic          r_dir_q;
  logic          r_lap;
  seg_t          r_seg;

  tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .div  (div),
    .tick (w_tick)
  );

  // Wrap mode follows the dir pin live; bounce mode owns the direction.
  assign w_dir_eff = mode ? r_dir_q : dir;

  always_comb begin
    w_pos_next = r_pos;
    w_dir_next = w_dir_eff;
    w_lap_next = 1'b0;
    if (w_tick) begin
      if (int'(r_pos) >= N_SEG) begin
        w_pos_next = '0;
      end else if (!mode) begin
        if (!w_dir_eff) begin
          if (r_pos == LAST) begin
            w_pos_next = '0;
            w_lap_next = 1'b1;
          end else begin
            w_pos_next = r_pos + ONE;
          end
        end else begin
          if (r_pos == '0) begin
            w_pos_next = LAST;
            w_lap_next = 1'b1;
          end else begin
            w_pos_next = r_pos - ONE;
          end
        end
      end else begin
        // Bounce: reverse at either end, stepping straight back off it.
        if (!r_dir_q) begin
          if (r_pos == LAST) begin
            w_dir_next = 1'b1;
            w_pos_next = PENULT;
            w_lap_next = 1'b1;
          end else begin
            w_pos_next = r_pos + ONE;
          end
        end else begin
          if (r_pos == '0) begin
            w_dir_next = 1'b0;
            w_pos_next = ONE;
            w_lap_next = 1'b1;
          end else begin
            w_pos_next = r_pos - ONE;
          end
        end
      end
    end
  end

  // seg is decoded from the next position so it lands with pos, not after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos   <= '0;
      r_dir_q <= 1'b0;
      r_lap   <= 1'b0;
      r_seg   <= onehot_seg(3'd0, COMMON_ANODE);
    end else begin
      r_pos   <= w_pos_next;
      r_dir_q <= w_dir_next;
      r_lap   <= w_lap_next;
      r_seg   <= onehot_seg(3'(w_pos_next), COMMON_ANODE);
    end
  end

  assign seg = r_seg;
  assign pos = r_pos;
  assign lap = r_lap;

endmodule

// File: tb/tb_seg_chaser.sv
// Scoreboard bench: three chaser variants share one stimulus stream and are
// checked against a ring-walk model of the chase rules.
`timescale 1ns/1ps
module tb_seg_chaser;

  localparam int DW = 26;
  localparam int NS [3] = '{6, 2, 7};
  localparam bit CA [3] = '{1'b1, 1'b0, 1'b0};

  logic          clk;
  logic          reset;
  logic          en;
  logic          dir;
  logic          mode;
  logic [DW-1:0] div;

  logic [6:0] seg0, seg1, seg2;
  logic [2:0] pos0, pos2;
  logic [0:0] pos1;
  logic       lap0, lap1, lap2;

  seg_chaser #(.N_SEG(6), .COMMON_ANODE(1'b1), .DIV_W(DW)) u_dut0 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .div(div),
    .seg(seg0), .pos(pos0), .lap(lap0)
  );
  seg_chaser #(.N_SEG(2), .COMMON_ANODE(1'b0), .DIV_W(DW)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .div(div),
    .seg(seg1), .pos(pos1), .lap(lap1)
  );
  seg_chaser #(.N_SEG(7), .COMMON_ANODE(1'b0), .DIV_W(DW)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .div(div),
    .seg(seg2), .pos(pos2), .lap(lap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] pos;
    logic [6:0] seg;
    logic       lap;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_cycle  = 0;

  // Reference model state: prescale count, and per ring its position and
  // heading (+1 forward / -1 reverse).
  int m_cnt;
  int m_pos [3];
  int m_head [3];

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, k, n_cycle, act, exp);
  endtask

  function automatic exp_t expect_of(input int k);
    exp_t e;
    logic [6:0] lit;
    lit   = 7'(1 << (6 - m_pos[k]));
    e.pos = 3'(m_pos[k]);
    e.seg = CA[k] ? ~lit : lit;
    e.lap = 1'b0;
    return e;
  endfunction

  // Effect of the coming clock edge under the currently driven inputs.
  task automatic model_step();
    bit   tick;
    int   np;
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      e = '0;
      if (reset) begin
        m_pos[k]  = 0;
        m_head[k] = 1;
        e = expect_of(k);
      end else begin
        tick = en && (m_cnt >= int'(div));
        if (!mode) m_head[k] = dir ? -1 : 1;
        if (tick) begin
          np = m_pos[k] + m_head[k];
          if (np < 0 || np >= NS[k]) begin
            if (!mode) begin
              np = (np + NS[k]) % NS[k];
            end else begin
              m_head[k] = -m_head[k];
              np = m_pos[k] + m_head[k];
            end
            m_pos[k] = np;
            e = expect_of(k);
            e.lap = 1'b1;
          end else begin
            m_pos[k] = np;
            e = expect_of(k);
          end
        end else begin
          e = expect_of(k);
        end
      end
      if (k == 0) q0.push_back(e);
      else if (k == 1) q1.push_back(e);
      else q2.push_back(e);
    end
    if (reset) m_cnt = 0;
    else if (en) m_cnt = (m_cnt >= int'(div)) ? 0 : m_cnt + 1;
  endtask

  task automatic cyc(input logic r, input logic e, input logic d, input logic m, input int dv);
    reset = r; en = e; dir = d; mode = m; div = DW'(dv);
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic e, input logic d, input logic m, input int dv);
    for (int i = 0; i < n; i++) cyc(1'b0, e, d, m, dv);
  endtask

  // Monitor: every edge each DUT presents pos/seg/lap; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      n_cycle++;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("pos", 0, int'(pos0), int'(e.pos));
        chk("seg", 0, int'(seg0), int'(e.seg));
        chk("lap", 0, int'(lap0), int'(e.lap));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("pos", 1, int'(pos1), int'(e.pos));
        chk("seg", 1, int'(seg1), int'(e.seg));
        chk("lap", 1, int'(lap1), int'(e.lap));
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("pos", 2, int'(pos2), int'(e.pos));
        chk("seg", 2, int'(seg2), int'(e.seg));
        chk("lap", 2, int'(lap2), int'(e.lap));
      end
    end
  end

  initial begin
    logic r_d, r_m, r_e, r_r;
    int   r_div;

    m_cnt = 0;
    // Wrap forward, one tick per cycle.
    cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
    run(14, 1, 0, 0, 0);
    // Slow ticks, then a freeze and resume mid-period.
    cyc(1, 1, 0, 0, 3);
    run(9, 1, 0, 0, 3);
    run(10, 0, 0, 0, 3);
    run(10, 1, 0, 0, 3);
    // Wrap reverse.
    cyc(1, 1, 1, 0, 0);
    run(8, 1, 1, 0, 0);
    // Bounce.
    cyc(1, 1, 0, 1, 0);
    run(14, 1, 0, 1, 0);
    // Period shortened below the running count.
    cyc(1, 1, 0, 0, 100);
    run(20, 1, 0, 0, 100);
    run(14, 1, 0, 0, 5);
    // Reset in the middle of a bounce reverse leg.
    cyc(1, 1, 0, 1, 0);
    run(7, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    run(3, 1, 0, 1, 0);
    // Mode switch back to wrap mid-bounce adopts dir at once.
    run(6, 1, 0, 1, 0);
    run(4, 1, 0, 0, 0);

    // Randomized traffic.
    r_d = 0; r_m = 0; r_div = 1;
    for (int i = 0; i < 800; i++) begin
      r_r = ($urandom_range(0, 99) == 0);
      r_e = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0)  r_d = ~r_d;
      if ($urandom_range(0, 19) == 0) r_m = ~r_m;
      if ($urandom_range(0, 29) == 0) r_div = int'($urandom_range(0, 4));
      cyc(r_r, r_e, r_d, r_m, r_div);
    end

    @(posedge clk);
    #2;
    n_checks++;
    if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d entries left expected 0", q0.size() + q1.size() + q2.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
